// File: rtl/three_dee_frame_loader.sv
// three_dee_frame_loader: packs a byte stream row-major into a staging
// array and hands completed frames to a registered 2-D output array A.
// The staging array keeps filling while the previous frame is held on A,
// until the consumer acknowledges it.
//
// Ports:
//   CLK       clock, all state on rising edge
//   RST       asynchronous active-high reset
//   IN_DATA   element to load            IN_VALID  IN_DATA valid
//   IN_READY  loader accepts IN_DATA this cycle (combinational)
//   ABORT     discard the partially filled staging frame
//   A         presented frame [W-1:0] x [0:ROWS-1][0:COLS-1], registered
//   A_VALID   A holds an unacknowledged frame
//   A_ACK     consumer takes the frame on A
//   FRAME_CNT frames moved to A, wraps modulo 2^CNTW
module three_dee_frame_loader #(
  parameter int unsigned W    = 8,
  parameter int unsigned ROWS = 3,
  parameter int unsigned COLS = 4,
  parameter int unsigned CNTW = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [W-1:0]    IN_DATA,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic            ABORT,
  output logic [W-1:0]    A [0:ROWS-1][0:COLS-1],
  output logic            A_VALID,
  input  logic            A_ACK,
  output logic [CNTW-1:0] FRAME_CNT
);

  localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  localparam logic [0:0] ST_FILL = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [W-1:0]     staging_q [0:ROWS-1][0:COLS-1];
  logic [W-1:0]     staging_d [0:ROWS-1][0:COLS-1];
  logic [W-1:0]     a_q       [0:ROWS-1][0:COLS-1];
  logic [W-1:0]     a_d       [0:ROWS-1][0:COLS-1];
  logic             a_valid_q, a_valid_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;

  logic accept;
  logic slot_free;
  logic xfer;

  // Ready is combinational so a byte can be taken in the same cycle it is offered.
  assign IN_READY  = (state_q == ST_FILL) && !ABORT && !RST;
  assign accept    = IN_VALID && IN_READY;
  assign slot_free = !a_valid_q || A_ACK;
  assign xfer      = (state_q == ST_FULL) && slot_free;

  assign A         = a_q;
  assign A_VALID   = a_valid_q;
  assign FRAME_CNT = cnt_q;

  // Next-state logic: fill staging, then move it to A when the slot frees.
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    staging_d = staging_q;
    a_d       = a_q;
    a_valid_d = a_valid_q;
    cnt_d     = cnt_q;

    case (state_q)
      ST_FILL: begin
        if (ABORT) begin
          // Staging contents stay; they are overwritten by the next frame.
          row_d = '0;
          col_d = '0;
        end else if (accept) begin
          staging_d[row_q][col_q] = IN_DATA;
          if (col_q == COL_W'(COLS - 1)) begin
            col_d = '0;
            if (row_q == ROW_W'(ROWS - 1)) begin
              row_d   = '0;
              state_d = ST_FULL;
            end else begin
              row_d = row_q + ROW_W'(1);
            end
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      ST_FULL: begin
        if (slot_free) begin
          a_d     = staging_q;
          cnt_d   = cnt_q + CNTW'(1);
          state_d = ST_FILL;
        end
      end
      default: state_d = ST_FILL;
    endcase

    // A transfer on the same edge as an ack keeps A_VALID high (no bubble).
    if (xfer) begin
      a_valid_d = 1'b1;
    end else if (a_valid_q && A_ACK) begin
      a_valid_d = 1'b0;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ST_FILL;
      row_q     <= '0;
      col_q     <= '0;
      a_valid_q <= 1'b0;
      cnt_q     <= '0;
      for (int r = 0; r < int'(ROWS); r++) begin
        for (int c = 0; c < int'(COLS); c++) begin
          staging_q[r][c] <= '0;
          a_q[r][c]       <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      a_valid_q <= a_valid_d;
      cnt_q     <= cnt_d;
      staging_q <= staging_d;
      a_q       <= a_d;
    end
  end

endmodule

// File: tb/tb_three_dee_frame_loader.sv
// Bench for three_dee_frame_loader: directed steps plus random traffic,
// each cycle compared against a frame-level reference model.
module tb_three_dee_frame_loader;

  localparam int NEL = 12;

  logic       clk;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       abort_i;
  logic [7:0] a_w [0:2][0:3];
  logic       a_valid;
  logic       a_ack;
  logic [7:0] frame_cnt;

  int n_pass;
  int n_total;
  int n_fail;

  // Reference model: flat element list, fill position, held frame.
  int m_stage [NEL];
  int m_a     [NEL];
  int m_n;
  bit m_full;
  bit m_av;
  int m_cnt;

  three_dee_frame_loader dut (
    .CLK      (clk),
    .RST      (rst),
    .IN_DATA  (in_data),
    .IN_VALID (in_valid),
    .IN_READY (in_ready),
    .ABORT    (abort_i),
    .A        (a_w),
    .A_VALID  (a_valid),
    .A_ACK    (a_ack),
    .FRAME_CNT(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NEL; i++) begin
      m_stage[i] = 0;
      m_a[i]     = 0;
    end
    m_n = 0; m_full = 0; m_av = 0; m_cnt = 0;
  endtask

  // One clock edge of the frame-level behaviour.
  task automatic model_edge(input bit v, input int d, input bit ab, input bit ack);
    bit xfer;
    xfer = m_full && (!m_av || ack);
    if (!m_full) begin
      if (ab) m_n = 0;
      else if (v) begin
        m_stage[m_n] = d;
        m_n++;
        if (m_n == NEL) begin
          m_n = 0;
          m_full = 1;
        end
      end
    end else if (xfer) begin
      for (int i = 0; i < NEL; i++) m_a[i] = m_stage[i];
      m_cnt  = (m_cnt + 1) % 256;
      m_full = 0;
    end
    if (xfer) m_av = 1;
    else if (ack && m_av) m_av = 0;
  endtask

  task automatic check_outputs(input string ctx);
    check({ctx, ".a_valid"}, 32'(a_valid), 32'(m_av));
    check({ctx, ".frame_cnt"}, 32'(frame_cnt), 32'(m_cnt));
    for (int i = 0; i < NEL; i++)
      check($sformatf("%s.A[%0d][%0d]", ctx, i / 4, i % 4), 32'(a_w[i / 4][i % 4]), 32'(m_a[i]));
  endtask

  // Drive one cycle of inputs, check ready, clock, check outputs.
  task automatic step(input bit v, input int d, input bit ab, input bit ack);
    @(negedge clk);
    in_valid = v; in_data = 8'(d); abort_i = ab; a_ack = ack;
    #1;
    check("in_ready", 32'(in_ready), 32'(!m_full && !ab));
    @(posedge clk);
    model_edge(v, d, ab, ack);
    #1;
    check_outputs("post_edge");
  endtask

  // Reset asserted between edges; checks the asynchronous effect at once.
  task automatic rst_pulse();
    @(negedge clk);
    #2;
    rst = 1'b1; in_valid = 1'b1; abort_i = 1'b0;
    #1;
    model_reset();
    check("rst.in_ready", 32'(in_ready), 32'd0);
    check_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0; a_ack = 1'b0;
  endtask

  initial begin
    n_pass = 0; n_total = 0; n_fail = 0;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; abort_i = 1'b0; a_ack = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    check("reset.in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // First frame 0x00..0x0B, no ack.
    for (int i = 0; i < NEL; i++) step(1, i, 0, 0);
    check("f1.not_yet_valid", 32'(a_valid), 32'd0);
    step(0, 0, 0, 0);
    check("f1.a_valid", 32'(a_valid), 32'd1);
    check("f1.A00", 32'(a_w[0][0]), 32'h00);
    check("f1.A03", 32'(a_w[0][3]), 32'h03);
    check("f1.A10", 32'(a_w[1][0]), 32'h04);
    check("f1.A23", 32'(a_w[2][3]), 32'h0B);
    check("f1.cnt", 32'(frame_cnt), 32'd1);

    // Second frame while A unacked, then backpressure, then ack-with-transfer.
    for (int i = 0; i < NEL; i++) step(1, 'h10 + i, 0, 0);
    step(1, 'h99, 0, 0);
    check("f2.held_ready", 32'(in_ready), 32'd0);
    check("f2.held_A23", 32'(a_w[2][3]), 32'h0B);
    step(0, 0, 0, 1);
    check("f2.A23", 32'(a_w[2][3]), 32'h1B);
    check("f2.a_valid", 32'(a_valid), 32'd1);
    check("f2.cnt", 32'(frame_cnt), 32'd2);

    // Ack alone drops A_VALID; then abort after 5 bytes, abort+valid drops byte.
    step(0, 0, 0, 1);
    check("ack.a_valid", 32'(a_valid), 32'd0);
    check("ack.A23_kept", 32'(a_w[2][3]), 32'h1B);
    for (int i = 0; i < 5; i++) step(1, 'h50 + i, 0, 0);
    step(1, 'h77, 1, 0);
    for (int i = 0; i < NEL; i++) step(1, 'h20 + i, 0, 0);
    step(0, 0, 0, 0);
    for (int i = 0; i < NEL; i++)
      check($sformatf("abort.A%0d", i), 32'(a_w[i / 4][i % 4]), 32'h20 + 32'(i));

    // Reset mid-frame with a frame held on A, then a clean reload.
    for (int i = 0; i < 7; i++) step(1, 'h60 + i, 0, 0);
    rst_pulse();
    for (int i = 0; i < NEL; i++) step(1, 'h30 + i, 0, 0);
    step(0, 0, 0, 0);
    check("post_rst.A00", 32'(a_w[0][0]), 32'h30);
    check("post_rst.A23", 32'(a_w[2][3]), 32'h3B);
    check("post_rst.cnt", 32'(frame_cnt), 32'd1);

    // Ack held high: one frame per 13 cycles, 256 frames wrap the counter.
    rst_pulse();
    for (int i = 0; i < 10 * 13; i++) step(1, int'($urandom_range(0, 255)), 0, 1);
    check("period.cnt10", 32'(frame_cnt), 32'd10);
    for (int i = 0; i < 246 * 13; i++) step(1, int'($urandom_range(0, 255)), 0, 1);
    check("wrap.cnt0", 32'(frame_cnt), 32'd0);
    check("wrap.a_valid", 32'(a_valid), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 600; i++)
      step(bit'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)),
           bit'($urandom_range(0, 19) == 0), bit'($urandom_range(0, 2) == 0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
